// File: rtl/add_seq.sv
// Multi-word sequential adder: rippling one 2-bit full-adder slice per cycle,
// least-significant slice first, with operand and result valid/ready handshakes.
module add_seq #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_co,
    output logic             busy
);

    localparam int N     = WIDTH / 2;
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [WIDTH-1:0] SLICE_MASK = WIDTH'(2'b11);
    localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(N - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    function automatic logic maj3(input logic x, input logic y, input logic z);
        return (x & y) | (x & z) | (y & z);
    endfunction

    // Returns {cout, s1, s0} for one 2-bit slice.
    function automatic logic [2:0] slice_add(input logic [1:0] a, input logic [1:0] b,
                                             input logic ci);
        logic s0;
        logic c1;
        logic s1;
        logic co;
        s0 = a[0] ^ b[0] ^ ci;
        c1 = maj3(a[0], b[0], ci);
        s1 = a[1] ^ b[1] ^ c1;
        co = maj3(a[1], b[1], c1);
        return {co, s1, s0};
    endfunction

    state_t             state_r;
    state_t             state_nxt_s;
    logic [WIDTH-1:0]   a_r;
    logic [WIDTH-1:0]   b_r;
    logic [WIDTH-1:0]   sum_r;
    logic               c_r;
    logic [IDX_W-1:0]   idx_r;
    logic [WIDTH-1:0]   out_sum_r;
    logic               out_co_r;
    logic               in_ready_r;
    logic               out_valid_r;
    logic               busy_r;

    logic               in_ready_nxt_s;
    logic               out_valid_nxt_s;
    logic               busy_nxt_s;
    logic [IDX_W:0]     bit_pos_s;
    logic [1:0]         slice_a_s;
    logic [1:0]         slice_b_s;
    logic [2:0]         slice_res_s;
    logic [WIDTH-1:0]   sum_upd_s;
    logic               last_slice_s;

    // Current slice operands, slice result and the merged partial sum.
    always_comb begin
        bit_pos_s    = {idx_r, 1'b0};
        slice_a_s    = 2'(a_r >> bit_pos_s);
        slice_b_s    = 2'(b_r >> bit_pos_s);
        slice_res_s  = slice_add(slice_a_s, slice_b_s, c_r);
        sum_upd_s    = (sum_r & ~(SLICE_MASK << bit_pos_s))
                     | (WIDTH'(slice_res_s[1:0]) << bit_pos_s);
        last_slice_s = (idx_r == IDX_LAST);
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next-state logic; unreachable encodings recover to IDLE.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (in_valid) begin
                    state_nxt_s = ST_RUN;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (last_slice_s) begin
                    state_nxt_s = ST_DONE;
                end else begin
                    state_nxt_s = ST_RUN;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_DONE;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // FSM output decode from the next state, so handshake flags come straight off flops.
    always_comb begin
        in_ready_nxt_s  = 1'b0;
        out_valid_nxt_s = 1'b0;
        busy_nxt_s      = 1'b0;
        case (state_nxt_s)
            ST_IDLE: begin
                in_ready_nxt_s = 1'b1;
            end
            ST_RUN: begin
                busy_nxt_s = 1'b1;
            end
            ST_DONE: begin
                out_valid_nxt_s = 1'b1;
                busy_nxt_s      = 1'b1;
            end
            default: begin
                in_ready_nxt_s = 1'b1;
            end
        endcase
    end

    // Registered handshake and status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            in_ready_r  <= in_ready_nxt_s;
            out_valid_r <= out_valid_nxt_s;
            busy_r      <= busy_nxt_s;
        end
    end

    // Operand capture, slice-per-cycle accumulation and result hand-off.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_r       <= '0;
            b_r       <= '0;
            sum_r     <= '0;
            c_r       <= 1'b0;
            idx_r     <= '0;
            out_sum_r <= '0;
            out_co_r  <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (in_valid) begin
                        a_r   <= in_a;
                        b_r   <= in_b;
                        sum_r <= '0;
                        c_r   <= 1'b0;
                        idx_r <= '0;
                    end else begin
                        a_r   <= a_r;
                        b_r   <= b_r;
                    end
                end
                ST_RUN: begin
                    sum_r <= sum_upd_s;
                    c_r   <= slice_res_s[2];
                    idx_r <= idx_r + IDX_W'(1);
                    // The result register only moves when the last slice lands,
                    // keeping out_sum/out_co stable outside DONE.
                    if (last_slice_s) begin
                        out_sum_r <= sum_upd_s;
                        out_co_r  <= slice_res_s[2];
                    end else begin
                        out_sum_r <= out_sum_r;
                        out_co_r  <= out_co_r;
                    end
                end
                ST_DONE: begin
                    out_sum_r <= out_sum_r;
                    out_co_r  <= out_co_r;
                end
                default: begin
                    idx_r <= '0;
                    c_r   <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign busy      = busy_r;
    assign out_sum   = out_sum_r;
    assign out_co    = out_co_r;

endmodule
